// File: rtl/audio_stream_ctrl.sv
// Playback controller for the audio sample FIFO: occupancy tracking, priming,
// divider-paced sample pops, low-watermark refill request and underrun reporting.
module audio_stream_ctrl #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned LOW_WM = 4,
    parameter int unsigned PRIME  = 8,
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             prod_wr_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    output logic             refill_req_o,
    output logic             underrun_o,
    output logic [15:0]      underrun_cnt_o,
    output logic [LW-1:0]    level_o
);

    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0] WM_LVL    = LW'(LOW_WM);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FETCH
    } state_e;

    state_e           state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             underrun_q, underrun_d;
    logic             refill_q, refill_d;
    logic [15:0]      ucnt_q, ucnt_d;
    logic [DIV_W-1:0] eff_div;
    logic             tick, rd_en, wr_acc, rd_acc;

    assign eff_div = (clk_div_i < DIV_W'(2)) ? DIV_W'(2) : clk_div_i;
    assign tick    = (cnt_q == '0);
    // Disable wins over a coincident tick so no sample is popped on the way to IDLE.
    assign rd_en   = enable_i && (state_q == ST_RUN) && tick && !fifo_empty_i;
    assign wr_acc  = prod_wr_i && !fifo_full_i;
    assign rd_acc  = rd_en && !fifo_empty_i;

    always_comb begin
        level_d = level_q;
        if (wr_acc && !rd_acc && (level_q != LEVEL_MAX)) begin
            level_d = level_q + LW'(1);
        end else if (rd_acc && !wr_acc && (level_q != '0)) begin
            level_d = level_q - LW'(1);
        end
        refill_d = (level_d <= WM_LVL);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        if (!enable_i) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sample_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_PRIME;
                ST_PRIME: begin
                    if ((level_q >= PRIME_LVL) || fifo_full_i) begin
                        cnt_d   = eff_div;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        cnt_d = eff_div;
                        if (!fifo_empty_i) begin
                            state_d = ST_FETCH;
                        end else begin
                            sample_d   = '0;
                            valid_d    = 1'b1;
                            underrun_d = 1'b1;
                            if (ucnt_q != '1) ucnt_d = ucnt_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end
                end
                ST_FETCH: begin
                    sample_d = fifo_rdata_i;
                    valid_d  = 1'b1;
                    state_d  = ST_RUN;
                    if (!tick) cnt_d = cnt_q - DIV_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            cnt_q      <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            refill_q   <= 1'b1;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            refill_q   <= refill_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign fifo_rd_en_o   = rd_en;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign refill_req_o   = refill_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ucnt_q;
    assign level_o        = level_q;

endmodule
